// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spart_pkg
// Description : Shared constants for the SPART bus-interface slice: register
//               address map, status-byte bit positions, TX holding-register
//               state encoding and the default divisor width.
// Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

    // Default baud divisor width: DB high byte plus DB low byte.
    localparam int c_DIV_W_DEFAULT = 16;

    // Register address map on ioaddr.
    localparam logic [1:0] ADDR_TXRX = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    // Bit positions inside the status byte.
    localparam int c_STAT_TBR    = 0;
    localparam int c_STAT_RDA    = 1;
    localparam int c_STAT_TX_OVR = 2;
    localparam int c_STAT_RX_OVR = 3;

    // TX holding-register state encoding.
    localparam logic [0:0] c_TX_EMPTY = 1'b0;
    localparam logic [0:0] c_TX_FULL  = 1'b1;

endpackage : spart_pkg
`default_nettype wire

// File: rtl/spart_brg.sv
`default_nettype none
// ============================================================================
// Module      : spart_brg
// Description : Baud-rate generator. A down counter reloads from the divisor
//               each time it reaches zero and emits a one-cycle brg_tick, so
//               the tick period is divisor+1 cycles. A divisor of zero parks
//               the counter at zero with no ticks.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               divisor       - current full divisor value
//               load          - force a reload from divisor (no tick issued)
//               brg_tick      - one-cycle enable pulse at 16x baud
// Revision    : 1.0 - initial release
// ============================================================================
module spart_brg
    import spart_pkg::*;
#(
    parameter int DIV_W = c_DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic             load,
    output logic             brg_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (divisor == '0) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (load) begin
            // A divisor update restarts the period without a tick.
            r_cnt  <= divisor;
            r_tick <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt  <= divisor;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt - DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

    assign brg_tick = r_tick;

endmodule : spart_brg
`default_nettype wire

// File: rtl/spart_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : spart_bus_if
// Description : SPART register/bus-interface stage. Decodes iocs/iorw/ioaddr
//               accesses on the shared databus, holds the TX holding
//               register, RX data register, status and divisor bytes, hands
//               bytes to the TX shift core, captures bytes from the RX core
//               and hosts the baud-rate generator.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               iocs, iorw    - chip select, 1=read / 0=write
//               ioaddr        - register address
//               databus       - shared bidirectional data bus
//               tbr, rda      - transmit buffer ready, receive data available
//               tx_data       - byte for the TX core
//               tx_start      - one-cycle load pulse for the TX core
//               tx_busy       - TX core is shifting
//               rx_data       - byte from the RX core
//               rx_valid      - one-cycle pulse qualifying rx_data
//               brg_tick      - one-cycle enable pulse at 16x baud
// Build macro : SPART_OVERRUN_EN - implements sticky tx_ovr/rx_ovr flags in
//               status bits 2 and 3; otherwise those bits read 0.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_bus_if
    import spart_pkg::*;
#(
    parameter int DIV_W = c_DIV_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       tbr,
    output logic       rda,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       brg_tick
);

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic w_wr;
    logic w_rd;
    logic w_wr_tx;
    logic w_rd_rx;
    logic w_rd_stat;
    logic w_wr_dbl;
    logic w_wr_dbh;

    assign w_wr      = iocs & ~iorw;
    assign w_rd      = iocs &  iorw;
    assign w_wr_tx   = w_wr & (ioaddr == ADDR_TXRX);
    assign w_rd_rx   = w_rd & (ioaddr == ADDR_TXRX);
    assign w_rd_stat = w_rd & (ioaddr == ADDR_STAT);
    assign w_wr_dbl  = w_wr & (ioaddr == ADDR_DBL);
    assign w_wr_dbh  = w_wr & (ioaddr == ADDR_DBH);

    // ------------------------------------------------------------------
    // TX holding register
    // ------------------------------------------------------------------
    logic [0:0] r_tx_state;
    logic [7:0] r_tx_hold;
    logic       r_tbr;
    logic       r_tx_start;

    // The held byte is presented on tx_data continuously, so it is valid
    // in the cycle tx_start pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= c_TX_EMPTY;
            r_tx_hold  <= 8'h00;
            r_tbr      <= 1'b1;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_tx_state)
                c_TX_EMPTY: begin
                    if (w_wr_tx) begin
                        r_tx_hold  <= databus;
                        r_tbr      <= 1'b0;
                        r_tx_state <= c_TX_FULL;
                    end
                end
                c_TX_FULL: begin
                    // A write arriving while FULL is dropped, even in the
                    // cycle the held byte drains.
                    if (!tx_busy) begin
                        r_tx_start <= 1'b1;
                        r_tbr      <= 1'b1;
                        r_tx_state <= c_TX_EMPTY;
                    end
                end
                default: begin
                    r_tx_state <= c_TX_EMPTY;
                end
            endcase
        end
    end

    assign tx_data  = r_tx_hold;
    assign tx_start = r_tx_start;
    assign tbr      = r_tbr;

    // ------------------------------------------------------------------
    // RX data register
    // ------------------------------------------------------------------
    logic [7:0] r_rx_data;
    logic       r_rda;

    // A new byte always wins over a same-cycle read clear: the bus still
    // returns the old byte combinationally while the new one is captured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data <= 8'h00;
            r_rda     <= 1'b0;
        end else if (rx_valid) begin
            r_rx_data <= rx_data;
            r_rda     <= 1'b1;
        end else if (w_rd_rx) begin
            r_rda     <= 1'b0;
        end
    end

    assign rda = r_rda;

    // ------------------------------------------------------------------
    // Overrun flags
    // ------------------------------------------------------------------
    logic w_tx_ovr;
    logic w_rx_ovr;

`ifdef SPART_OVERRUN_EN
    logic w_tx_drop;
    logic w_rx_overwrite;
    logic r_tx_ovr;
    logic r_rx_ovr;

    assign w_tx_drop      = w_wr_tx & (r_tx_state == c_TX_FULL);
    // Reading 00 in the same cycle consumes the old byte, so no overrun.
    assign w_rx_overwrite = rx_valid & r_rda & ~w_rd_rx;

    // Set events take priority over the status-read clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_ovr <= 1'b0;
            r_rx_ovr <= 1'b0;
        end else begin
            if (w_tx_drop) begin
                r_tx_ovr <= 1'b1;
            end else if (w_rd_stat) begin
                r_tx_ovr <= 1'b0;
            end
            if (w_rx_overwrite) begin
                r_rx_ovr <= 1'b1;
            end else if (w_rd_stat) begin
                r_rx_ovr <= 1'b0;
            end
        end
    end

    assign w_tx_ovr = r_tx_ovr;
    assign w_rx_ovr = r_rx_ovr;
`else
    assign w_tx_ovr = 1'b0;
    assign w_rx_ovr = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Divisor buffer and baud-rate generator
    // ------------------------------------------------------------------
    logic [7:0]       r_div_lo;
    logic [7:0]       r_div_hi;
    logic             r_div_load;
    logic [DIV_W-1:0] w_divisor;

    // The load strobe is registered so the generator reloads from the
    // already-updated divisor one cycle after the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_lo   <= 8'h00;
            r_div_hi   <= 8'h00;
            r_div_load <= 1'b0;
        end else begin
            r_div_load <= w_wr_dbl | w_wr_dbh;
            if (w_wr_dbl) begin
                r_div_lo <= databus;
            end
            if (w_wr_dbh) begin
                r_div_hi <= databus;
            end
        end
    end

    assign w_divisor = DIV_W'({r_div_hi, r_div_lo});

    spart_brg #(
        .DIV_W    (DIV_W)
    ) u_brg (
        .clk      (clk),
        .rst      (rst),
        .divisor  (w_divisor),
        .load     (r_div_load),
        .brg_tick (brg_tick)
    );

    // ------------------------------------------------------------------
    // Read-back mux and bus drive
    // ------------------------------------------------------------------
    logic [7:0] w_status;
    logic [7:0] w_rd_data;

    always_comb begin
        w_status                = 8'h00;
        w_status[c_STAT_TBR]    = r_tbr;
        w_status[c_STAT_RDA]    = r_rda;
        w_status[c_STAT_TX_OVR] = w_tx_ovr;
        w_status[c_STAT_RX_OVR] = w_rx_ovr;
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (ioaddr)
            ADDR_TXRX: w_rd_data = r_rx_data;
            ADDR_STAT: w_rd_data = w_status;
            ADDR_DBL:  w_rd_data = r_div_lo;
            ADDR_DBH:  w_rd_data = r_div_hi;
            default:   w_rd_data = 8'h00;
        endcase
    end

    assign databus = w_rd ? w_rd_data : 8'hzz;

endmodule : spart_bus_if
`default_nettype wire

// File: tb/tb_spart_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_spart_bus_if
// Description : Self-checking bench for spart_bus_if. The driver keeps a
//               register-level reference model of the block, pushes expected
//               read data and expected TX handoffs into queues, and a monitor
//               on the falling edge pops and compares them. Baud ticks are
//               checked by measuring intervals directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_bus_if;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    wire  [7:0] databus;
    logic       tbr;
    logic       rda;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       brg_tick;

    logic [7:0] drv_data = 8'h00;
    logic       drv_en = 1'b0;

    assign databus = drv_en ? drv_data : 8'hzz;

    always #5 clk = ~clk;

    spart_bus_if dut (
        .clk      (clk),
        .rst      (rst),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .tbr      (tbr),
        .rda      (rda),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .brg_tick (brg_tick)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: register contents as seen by the processor.
    logic       m_full, m_rda, m_txo, m_rxo;
    logic [7:0] m_txb, m_rxb, m_dlo, m_dhi;
    logic       exp_tbr, exp_rda;
    logic       chk_en = 1'b0;
    logic       busy_st = 1'b0;

    typedef struct { int c; logic [7:0] b; } tx_exp_t;
    typedef struct { logic [1:0] a; logic [7:0] v; } rd_exp_t;
    tx_exp_t tx_q[$];
    rd_exp_t rd_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_rda = 1'b0; m_txo = 1'b0; m_rxo = 1'b0;
        m_txb = 8'h00; m_rxb = 8'h00; m_dlo = 8'h00; m_dhi = 8'h00;
    endtask

    function automatic logic [7:0] read_model(input logic [1:0] a);
        logic [7:0] s;
        s = {4'b0000, m_rxo, m_txo, m_rda, ~m_full};
`ifndef SPART_OVERRUN_EN
        s[3:2] = 2'b00;
`endif
        case (a)
            2'd0:    return m_rxb;
            2'd1:    return s;
            2'd2:    return m_dlo;
            default: return m_dhi;
        endcase
    endfunction

    // One bus cycle: drive inputs, record expectations, advance the model,
    // then return #1 after the next rising edge.
    task automatic do_cycle(input logic r, input logic cs, input logic rw,
                            input logic [1:0] a, input logic [7:0] wd,
                            input logic busy, input logic rxv, input logic [7:0] rxd);
        logic wr, rd, was_full;
        tx_exp_t te;
        rd_exp_t re;
        rst = r; iocs = cs; iorw = rw; ioaddr = a; drv_data = wd;
        drv_en = cs & ~rw; tx_busy = busy; rx_valid = rxv; rx_data = rxd;
        exp_tbr = ~m_full;
        exp_rda = m_rda;
        chk_en  = 1'b1;
        wr = cs & ~rw;
        rd = cs & rw;
        if (rd && !r) begin
            re.a = a; re.v = read_model(a);
            rd_q.push_back(re);
        end
        if (r) begin
            model_reset();
        end else begin
            was_full = m_full;
            if (was_full && !busy) begin
                te.c = cyc + 1; te.b = m_txb;
                tx_q.push_back(te);
                m_full = 1'b0;
            end
            if (wr && a == 2'd0) begin
                if (was_full) m_txo = 1'b1;
                else begin m_full = 1'b1; m_txb = wd; end
            end
            if (rd && a == 2'd1) begin
                if (!(wr && a == 2'd0 && was_full)) m_txo = 1'b0;
                if (!(rxv && m_rda)) m_rxo = 1'b0;
            end
            if (rxv) begin
                if (m_rda && !(rd && a == 2'd0)) m_rxo = 1'b1;
                m_rxb = rxd;
                m_rda = 1'b1;
            end else if (rd && a == 2'd0) begin
                m_rda = 1'b0;
            end
            if (wr && a == 2'd2) m_dlo = wd;
            if (wr && a == 2'd3) m_dhi = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();                        do_cycle(0, 0, 0, 2'd0, 8'h00, busy_st, 0, 8'h00); endtask
    task automatic bwr(input logic [1:0] a, input logic [7:0] d); do_cycle(0, 1, 0, a, d, busy_st, 0, 8'h00); endtask
    task automatic brd(input logic [1:0] a);      do_cycle(0, 1, 1, a, 8'h00, busy_st, 0, 8'h00); endtask
    task automatic rxin(input logic [7:0] d);     do_cycle(0, 0, 0, 2'd0, 8'h00, busy_st, 1, d); endtask

    // Monitor: flags every cycle, TX handoffs and read data as they appear.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tbr", {31'd0, tbr}, {31'd0, exp_tbr});
            chk("rda", {31'd0, rda}, {31'd0, exp_rda});
            if (tx_q.size() > 0 && tx_q[0].c == cyc) begin
                chk("tx_start", {31'd0, tx_start}, 32'd1);
                chk("tx_data", {24'd0, tx_data}, {24'd0, tx_q[0].b});
                void'(tx_q.pop_front());
            end else begin
                chk("tx_start_idle", {31'd0, tx_start}, 32'd0);
            end
            if (iocs && iorw && !rst) begin
                if (rd_q.size() == 0) begin
                    chk("read_unexpected", 32'd1, 32'd0);
                end else begin
                    chk($sformatf("read_a%0d", rd_q[0].a), {24'd0, databus}, {24'd0, rd_q[0].v});
                    void'(rd_q.pop_front());
                end
            end
        end
    end

    // Wait for the first tick (latency from now) and the next (period).
    task automatic measure(input string nm, input int exp_lat, input int exp_per);
        int t_start, t0, t1;
        t_start = cyc; t0 = -1; t1 = -1;
        for (int i = 0; i < exp_per * 3 + 20 && t1 < 0; i++) begin
            idle();
            if (brg_tick) begin
                if (t0 < 0) t0 = cyc; else t1 = cyc;
            end
        end
        if (exp_lat > 0) chk({nm, "_latency"}, t0 - t_start, exp_lat);
        chk({nm, "_period"}, (t1 < 0) ? -1 : t1 - t0, exp_per);
    endtask

    initial begin
        int ticks;
        logic [7:0] d;
        logic cs, rw, rv, rr;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and divisor read-back.
        idle();
        brd(2'd2); brd(2'd3); brd(2'd1);

        // Baud generator: divisor 325 -> period 326.
        bwr(2'd2, 8'h45);
        bwr(2'd3, 8'h01);
        brd(2'd2); brd(2'd3);
        measure("brg325", 0, 326);
        // Divisor 3 with reload latency: tick 5 cycles after the write edge.
        bwr(2'd3, 8'h00);
        bwr(2'd2, 8'h03);
        measure("brg3", 5, 4);
        bwr(2'd2, 8'h01);
        measure("brg1", 3, 2);
        // Divisor 0: no ticks at all.
        bwr(2'd2, 8'h00);
        idle(); idle();
        ticks = 0;
        for (int i = 0; i < 60; i++) begin idle(); if (brg_tick) ticks++; end
        chk("brg0_ticks", ticks, 0);

        // TX handoff with idle core.
        busy_st = 1'b0;
        bwr(2'd0, 8'h55);
        idle(); idle();

        // TX overrun while the core is busy.
        busy_st = 1'b1;
        bwr(2'd0, 8'hA0);
        bwr(2'd0, 8'hA1);
        brd(2'd1); brd(2'd1);
        busy_st = 1'b0;
        idle(); idle();

        // RX capture, overwrite and same-cycle read/capture.
        rxin(8'h3C); brd(2'd0); brd(2'd1);
        rxin(8'h3C); rxin(8'h3D); brd(2'd0); brd(2'd1); brd(2'd1);
        rxin(8'h11);
        do_cycle(0, 1, 1, 2'd0, 8'h00, 1'b0, 1'b1, 8'h7E);
        brd(2'd1); brd(2'd0); brd(2'd1);

        // Reset while the holding register is FULL.
        busy_st = 1'b1;
        bwr(2'd0, 8'h99);
        do_cycle(1, 0, 0, 2'd0, 8'h00, 1'b1, 0, 8'h00);
        busy_st = 1'b0;
        idle(); idle(); idle();
        brd(2'd1); brd(2'd2);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 4) == 0) busy_st = ~busy_st;
            rr = ($urandom_range(0, 399) == 0);
            cs = !rr && ($urandom_range(0, 9) < 4);
            rw = $urandom_range(0, 1);
            rv = ($urandom_range(0, 6) == 0);
            d  = 8'($urandom);
            do_cycle(rr, cs, rw, 2'($urandom), d, busy_st, rv, 8'($urandom));
        end

        busy_st = 1'b0;
        repeat (4) idle();
        chk("tx_queue_drained", tx_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spart_bus_if
`default_nettype wire
